// File: rtl/blu_ntt_sched.sv
// Address/twiddle sequencer for one NTT (CT) or INTT (GS) pass over an N-point memory,
// with a fixed-latency write-back address delay line and inter-stage drain gaps.
module blu_ntt_sched #(
    parameter int LOG_N    = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             mode_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LOG_N-1:0] stage_o,
    output logic             rd_en_o,
    output logic [LOG_N-1:0] rd_addr0_o,
    output logic [LOG_N-1:0] rd_addr1_o,
    output logic [LOG_N-1:0] zeta_idx_o,
    output logic             is_gs_o,
    output logic             wr_en_o,
    output logic [LOG_N-1:0] wr_addr0_o,
    output logic [LOG_N-1:0] wr_addr1_o
);

    localparam int N    = 1 << LOG_N;
    localparam int HALF = N / 2;
    localparam int LW   = LOG_N + 1;
    localparam int DW   = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [LOG_N-1:0] pair_cnt;
    logic [LOG_N-1:0] grp_off;
    logic [LOG_N-1:0] len_cur;
    logic [DW-1:0]    drain_cnt;
    logic             last_pair, last_in_grp, last_drain, last_stage;

    // Butterfly span: shrinking from N/2 for CT, growing from 1 for GS.
    function automatic logic [LOG_N-1:0] stage_len(input logic [LOG_N-1:0] s, input logic gs);
        logic [LOG_N:0] full;
        if (gs) full = LW'(1) << s;
        else    full = (LW'(N) >> s) >> 1;
        return full[LOG_N-1:0];
    endfunction

    assign len_cur     = stage_len(stage_o, is_gs_o);
    assign last_pair   = (pair_cnt == LOG_N'(HALF - 1));
    assign last_in_grp = (grp_off == len_cur - 1'b1);
    assign last_drain  = (drain_cnt == DW'(PIPE_LAT - 1));
    assign last_stage  = (stage_o == LOG_N'(LOG_N - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state <= S_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_RUN;
            S_RUN:   if (last_pair) state_nxt = S_DRAIN;
            S_DRAIN: if (last_drain) state_nxt = last_stage ? S_DONE : S_RUN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state != S_IDLE);
        done_o  = (state == S_DONE);
        rd_en_o = (state == S_RUN);
    end

    // Issue registers advance on the pair just issued; on the final pair of a stage they
    // hold, so the bus keeps its last value through DRAIN and k is stepped only at the
    // start of the next stage's first group.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            stage_o    <= '0;
            is_gs_o    <= 1'b0;
            pair_cnt   <= '0;
            grp_off    <= '0;
            drain_cnt  <= '0;
            rd_addr0_o <= '0;
            rd_addr1_o <= '0;
            zeta_idx_o <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    is_gs_o    <= mode_i;
                    stage_o    <= '0;
                    pair_cnt   <= '0;
                    grp_off    <= '0;
                    rd_addr0_o <= '0;
                    rd_addr1_o <= stage_len('0, mode_i);
                    zeta_idx_o <= mode_i ? LOG_N'(N - 1) : LOG_N'(1);
                end
                S_RUN: begin
                    drain_cnt <= '0;
                    if (!last_pair) begin
                        pair_cnt <= pair_cnt + 1'b1;
                        if (last_in_grp) begin
                            grp_off    <= '0;
                            rd_addr0_o <= rd_addr0_o + len_cur + 1'b1;
                            rd_addr1_o <= rd_addr1_o + len_cur + 1'b1;
                            zeta_idx_o <= is_gs_o ? zeta_idx_o - 1'b1 : zeta_idx_o + 1'b1;
                        end else begin
                            grp_off    <= grp_off + 1'b1;
                            rd_addr0_o <= rd_addr0_o + 1'b1;
                            rd_addr1_o <= rd_addr1_o + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (last_drain && !last_stage) begin
                        stage_o    <= stage_o + 1'b1;
                        pair_cnt   <= '0;
                        grp_off    <= '0;
                        rd_addr0_o <= '0;
                        rd_addr1_o <= stage_len(stage_o + 1'b1, is_gs_o);
                        zeta_idx_o <= is_gs_o ? zeta_idx_o - 1'b1 : zeta_idx_o + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic [PIPE_LAT-1:0] vld_q;
    logic [LOG_N-1:0]    a0_q [PIPE_LAT];
    logic [LOG_N-1:0]    a1_q [PIPE_LAT];

    // NOTE: the address stages are reset too, because every output must read 0 in reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                a0_q[i] <= '0;
                a1_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en_o;
            a0_q[0]  <= rd_addr0_o;
            a1_q[0]  <= rd_addr1_o;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                a0_q[i]  <= a0_q[i-1];
                a1_q[i]  <= a1_q[i-1];
            end
        end
    end

    assign wr_en_o    = vld_q[PIPE_LAT-1];
    assign wr_addr0_o = a0_q[PIPE_LAT-1];
    assign wr_addr1_o = a1_q[PIPE_LAT-1];

endmodule

// File: doc/blu_ntt_sched.md
Name: blu_ntt_sched

Overview:
- Sequences one full NTT or INTT over an N-point coefficient memory through a single pipelined butterfly unit (CT for NTT, GS for INTT).
- Issues one butterfly pair per cycle: read addresses, zeta index and GS/CT select.
- Delays the addresses by the fixed pipeline latency to produce write-back addresses.
- Inserts a drain gap between stages so no stage reads a coefficient before the previous stage has written it.

Parameters:
- LOG_N, 8: log2 of transform length; N = 2^LOG_N; number of stages = LOG_N.
- PIPE_LAT, 4: cycles from read issue (rd_en_o) to write-back (wr_en_o); covers memory read plus butterfly latency; must be >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  0 = forward NTT, 1 = inverse INTT; latched at start.
- busy_o  out  1  high in RUN, DRAIN and DONE.
- done_o  out  1  one-cycle pulse at completion.
- stage_o  out  LOG_N  current stage index, 0..LOG_N-1.
- rd_en_o  out  1  butterfly pair issue strobe.
- rd_addr0_o  out  LOG_N  first operand address j.
- rd_addr1_o  out  LOG_N  second operand address j+len.
- zeta_idx_o  out  LOG_N  twiddle ROM index for this pair.
- is_gs_o  out  1  butterfly select; equals the latched mode; stable for the whole run.
- wr_en_o  out  1  write-back strobe; equals rd_en_o delayed PIPE_LAT cycles.
- wr_addr0_o  out  LOG_N  rd_addr0_o delayed PIPE_LAT cycles.
- wr_addr1_o  out  LOG_N  rd_addr1_o delayed PIPE_LAT cycles.

Behaviour:
- Reset (async, any state): FSM to IDLE; delay line valid bits cleared; all outputs 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start_i=1. mode_i latched into is_gs_o at that edge. stage=0; k=1 for NTT, k=N-1 for INTT.
- start_i is ignored outside IDLE, including in DONE.
- len per stage:
  - NTT: len = N>>(stage+1), i.e. N/2 down to 1.
  - INTT: len = 1<<stage, i.e. 1 up to N/2.
- Issue order within a stage: groups start = 0, 2len, 4len, ... ascending; inside a group, j = start .. start+len-1 ascending.
- Pair addresses: rd_addr0_o = j, rd_addr1_o = j+len.
- Twiddle: zeta_idx_o = k for every pair of a group. On leaving a group, k increments (NTT) or decrements (INTT). k is never reset between stages.
- RUN issues exactly N/2 pairs, one per cycle, rd_en_o=1 every RUN cycle. After the last pair of a stage: -> DRAIN.
- DRAIN lasts exactly PIPE_LAT cycles with rd_en_o=0. The last write of the stage occurs in the final DRAIN cycle.
- From DRAIN: if stage < LOG_N-1, then stage+1 and -> RUN; otherwise -> DONE.
- DONE lasts one cycle: done_o=1, busy_o=1; then -> IDLE with busy_o=0.
- Timing, with start sampled at edge 0:
  - first rd_en_o in cycle 1.
  - stage s occupies cycles s*(N/2+PIPE_LAT)+1 .. (s+1)*(N/2+PIPE_LAT).
  - done_o in cycle LOG_N*(N/2+PIPE_LAT)+1.
- Write path: PIPE_LAT-deep shift register carrying {valid, addr0, addr1}. Shifts every cycle, independent of FSM state. wr_* never asserted while the line holds no valid entries.
- rd_addr*/zeta_idx_o hold their last value when rd_en_o=0; consumers qualify with rd_en_o.
- Boundary: when k passes its final value (N-1 after last NTT group, 0 after last INTT group), it is not used again. Width wrap is harmless.
- Back-to-back: a new start_i is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- LOG_N=3, PIPE_LAT=2, NTT, start at cycle 0 -> required response:
  - stage0: (0,4)(1,5)(2,6)(3,7), all zeta 1.
  - stage1: (0,2)(1,3) z2; (4,6)(5,7) z3.
  - stage2: (0,1)z4 (2,3)z5 (4,5)z6 (6,7)z7.
  - rd_en_o in cycles 1-4, 7-10, 13-16; done_o in cycle 19 only.
- Same config, INTT -> is_gs_o=1 and required response:
  - stage0: (0,1)z7 (2,3)z6 (4,5)z5 (6,7)z4.
  - stage1: (0,2)(1,3) z3; (4,6)(5,7) z2.
  - stage2: (0,4)(1,5)(2,6)(3,7) z1.
- Write-back check -> every wr_en_o/wr_addr pair equals the rd pair exactly 2 cycles earlier. The last stage-0 write occurs in cycle 6, before the first stage-1 read in cycle 7.
- start_i held high through an entire run -> no restart mid-run. The second run's first rd_en_o occurs in cycle 21 (start sampled in the IDLE cycle 20).
- Assert reset_ni low in cycle 9 during stage1 -> all outputs 0 asynchronously, including wr_en_o while writes are still pending. After release, state is IDLE, with no stale writes and no done_o.
- LOG_N=8, PIPE_LAT=4, NTT -> 128 issues per stage; final zeta_idx_o=255; done_o in cycle 8*132+1 = 1057.
